axi_ram_responder: RTL and testbench

Synthesizable AXI4 slave that answers the core's instruction-fetch and data-access master ports from an internal word-addressed RAM. It is the responder end of the core memory interface. Its first use is to stand in for the behavioural slave BFMs in core-level simulation. It also serves as on-chip scratch memory for FPGA bring-up. Read and write channels run independently, with one outstanding transaction per channel and INCR bursts only.

---
 rtl/axi_ram_responder.sv | 199 +++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_responder.sv
// AXI4 INCR-burst slave backed by a word-addressed RAM.
// Read and write channels run independently, one burst each.
module axi_ram_responder #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_OFFSET_WIDTH   = 28,
   parameter int C_MEM_WORDS      = 2048
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic [C_OFFSET_WIDTH-1:0]     AWADDR,
   input  logic [7:0]                    AWLEN,
   input  logic                          AWVALID,
   output logic                          AWREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
   input  logic                          WLAST,
   input  logic                          WVALID,
   output logic                          WREADY,
   output logic [1:0]                    BRESP,
   output logic                          BVALID,
   input  logic                          BREADY,
   input  logic [C_OFFSET_WIDTH-1:0]     ARADDR,
   input  logic [7:0]                    ARLEN,
   input  logic                          ARVALID,
   output logic                          ARREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]                    RRESP,
   output logic                          RLAST,
   output logic                          RVALID,
   input  logic                          RREADY
);

   localparam int NB = C_AXI_DATA_WIDTH / 8;
   localparam int AW = $clog2(C_MEM_WORDS);
   // one guard bit so a burst past the top never wraps back into range
   localparam int IW = C_OFFSET_WIDTH - 1;
   localparam logic [IW-1:0] TOP = IW'(C_MEM_WORDS);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   logic [C_AXI_DATA_WIDTH-1:0] mem [C_MEM_WORDS];

   w_state_t w_state;
   w_state_t w_next;
   logic [IW-1:0] w_idx;
   logic [7:0] w_len;
   logic [7:0] w_cnt;
   logic w_err;
   logic w_last;
   logic w_inr;
   logic aw_hs;
   logic w_hs;

   r_state_t r_state;
   r_state_t r_next;
   logic [IW-1:0] r_idx;
   logic [7:0] r_len;
   logic [7:0] r_cnt;
   logic [C_AXI_DATA_WIDTH-1:0] r_data;
   logic [1:0] r_resp;
   logic r_lastq;
   logic r_inr;
   logic ar_hs;
   logic r_hs;

   logic unused;
   assign unused = ^{AWADDR[1:0], ARADDR[1:0]};

   assign w_last = (w_cnt == w_len);
   assign w_inr  = (w_idx < TOP);
   assign aw_hs  = AWVALID && AWREADY;
   assign w_hs   = WVALID && WREADY;

   assign r_inr  = (r_idx < TOP);
   assign ar_hs  = ARVALID && ARREADY;
   assign r_hs   = RVALID && RREADY;

   // write FSM state register
   always_ff @(posedge CLK) begin
      if (!RSTN) w_state <= W_IDLE;
      else       w_state <= w_next;
   end

   // write FSM next state and handshake outputs, all low in reset
   always_comb begin
      w_next  = w_state;
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      BVALID  = 1'b0;
      BRESP   = 2'b00;
      if (RSTN) begin
         case (w_state)
            W_IDLE: begin
               AWREADY = 1'b1;
               if (AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
               WREADY = 1'b1;
               if (WVALID && w_last) w_next = W_RESP;
            end
            W_RESP: begin
               BVALID = 1'b1;
               BRESP  = {w_err, 1'b0};
               if (BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
         endcase
      end
   end

   // write burst address, beat count and sticky error
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         w_idx <= '0;
         w_len <= '0;
         w_cnt <= '0;
         w_err <= 1'b0;
      end else if (aw_hs) begin
         w_idx <= {1'b0, AWADDR[C_OFFSET_WIDTH-1:2]};
         w_len <= AWLEN;
         w_cnt <= '0;
         w_err <= 1'b0;
      end else if (w_hs) begin
         w_idx <= w_idx + IW'(1);
         w_cnt <= w_cnt + 8'd1;
         if (!w_inr || (WLAST != w_last)) w_err <= 1'b1;
      end
   end

   // byte-masked RAM write; out-of-range beats are dropped
   always_ff @(posedge CLK) begin
      if (w_hs && w_inr) begin
         for (int b = 0; b < NB; b++) begin
            if (WSTRB[b]) mem[w_idx[AW-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
         end
      end
   end

   // read FSM state register
   always_ff @(posedge CLK) begin
      if (!RSTN) r_state <= R_IDLE;
      else       r_state <= r_next;
   end

   // read FSM next state and R-channel outputs, all low in reset
   always_comb begin
      r_next  = r_state;
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      RDATA   = '0;
      RRESP   = 2'b00;
      RLAST   = 1'b0;
      if (RSTN) begin
         case (r_state)
            R_IDLE: begin
               ARREADY = 1'b1;
               if (ARVALID) r_next = R_FETCH;
            end
            R_FETCH: r_next = R_DATA;
            R_DATA: begin
               RVALID = 1'b1;
               RDATA  = r_data;
               RRESP  = r_resp;
               RLAST  = r_lastq;
               if (RREADY) r_next = r_lastq ? R_IDLE : R_FETCH;
            end
            default: r_next = R_IDLE;
         endcase
      end
   end

   // read burst tracking and the registered RAM read (old data wins)
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_idx   <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_resp  <= 2'b00;
         r_lastq <= 1'b0;
      end else begin
         if (ar_hs) begin
            r_idx <= {1'b0, ARADDR[C_OFFSET_WIDTH-1:2]};
            r_len <= ARLEN;
            r_cnt <= '0;
         end else if (r_hs && !r_lastq) begin
            r_idx <= r_idx + IW'(1);
            r_cnt <= r_cnt + 8'd1;
         end
         if (r_state == R_FETCH) begin
            r_data  <= r_inr ? mem[r_idx[AW-1:0]] : '0;
            r_resp  <= r_inr ? 2'b00 : 2'b10;
            r_lastq <= (r_cnt == r_len);
         end
      end
   end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Bench for axi_ram_responder: directed bursts with a queue
// scoreboard drained by a negedge monitor on the B and R channels.
module tb_axi_ram_responder;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic [27:0] AWADDR;
   logic [7:0]  AWLEN;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [27:0] ARADDR;
   logic [7:0]  ARLEN;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
   } rbeat_t;

   rbeat_t     rq[$];
   logic [1:0] bq[$];
   logic [31:0] wd [8];
   int checks = 0;
   int errors = 0;
   string tname = "init";

   always #5 CLK = ~CLK;

   axi_ram_responder dut (
      .CLK(CLK), .RSTN(RSTN),
      .AWADDR(AWADDR), .AWLEN(AWLEN),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
      .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%s]: got %h expected %h",
                  name, tname, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s [%s]", name, tname);
   endtask

   // monitor: compare presented B/R against the queue heads
   always @(negedge CLK) begin
      if (BVALID) begin
         if (bq.size() == 0) fail("b_unexpected");
         else begin
            chk("bresp", BRESP, bq[0]);
            if (BREADY) void'(bq.pop_front());
         end
      end
      if (RVALID) begin
         if (rq.size() == 0) fail("r_unexpected");
         else begin
            chk("rbeat", {RDATA, RRESP, RLAST}, rq[0]);
            if (RREADY) void'(rq.pop_front());
         end
      end
   end

   task automatic push_r(input logic [31:0] d, input logic [1:0] r,
                         input logic l);
      rbeat_t e;
      e.d = d;
      e.r = r;
      e.l = l;
      rq.push_back(e);
   endtask

   task automatic aw_send(input logic [27:0] a, input logic [7:0] len);
      int k;
      AWADDR = a;
      AWLEN = len;
      AWVALID = 1'b1;
      k = 0;
      do begin @(negedge CLK); k++; end while (!AWREADY && k < 40);
      if (!AWREADY) fail("awready_timeout");
      @(posedge CLK);
      #1 AWVALID = 1'b0;
   endtask

   task automatic ar_send(input logic [27:0] a, input logic [7:0] len);
      int k;
      ARADDR = a;
      ARLEN = len;
      ARVALID = 1'b1;
      k = 0;
      do begin @(negedge CLK); k++; end while (!ARREADY && k < 40);
      if (!ARREADY) fail("arready_timeout");
      @(posedge CLK);
      #1 ARVALID = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                         input logic l);
      int k;
      WDATA = d;
      WSTRB = s;
      WLAST = l;
      WVALID = 1'b1;
      k = 0;
      do begin @(negedge CLK); k++; end while (!WREADY && k < 40);
      if (!WREADY) fail("wready_timeout");
      @(posedge CLK);
      #1 WVALID = 1'b0;
   endtask

   task automatic write_burst(input logic [27:0] a, input int len,
                              input logic [3:0] s, input int lastpos,
                              input logic [1:0] bexp);
      bq.push_back(bexp);
      aw_send(a, len[7:0]);
      for (int i = 0; i <= len; i++) w_beat(wd[i], s, i == lastpos);
   endtask

   task automatic wait_rvalid(output int n);
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         if (RVALID) begin
            n = k;
            break;
         end
      end
      if (n == 0) fail("rvalid_timeout");
   endtask

   task automatic read_burst(input logic [27:0] a, input int len,
                             input int stall);
      int n;
      ar_send(a, len[7:0]);
      for (int i = 0; i <= len; i++) begin
         RREADY = (i != stall);
         wait_rvalid(n);
         chk("r_latency", n, 2);
         if (i == stall) begin
            repeat (5) @(posedge CLK);
            #1 RREADY = 1'b1;
         end
         @(posedge CLK);
         #1;
      end
      RREADY = 1'b1;
   endtask

   task automatic drain;
      int k;
      k = 0;
      while ((bq.size() != 0 || rq.size() != 0) && k < 100) begin
         @(negedge CLK);
         k++;
      end
      if (bq.size() != 0 || rq.size() != 0) begin
         fail("drain_timeout");
         bq.delete();
         rq.delete();
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int n;
      RSTN = 1'b0;
      AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
      ARADDR = '0; ARLEN = '0; ARVALID = 1'b0;
      BREADY = 1'b1;
      RREADY = 1'b1;

      tname = "reset";
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      chk("outs_in_reset", {AWREADY, WREADY, BVALID, BRESP, ARREADY,
                            RVALID, RDATA, RRESP, RLAST}, 64'd0);
      @(posedge CLK);
      #1 RSTN = 1'b1;
      @(negedge CLK);
      chk("ready_after_rst", {AWREADY, ARREADY}, 2'b11);
      @(posedge CLK);
      #1;

      tname = "single";
      wd[0] = 32'hDEADBEEF;
      write_burst(28'h10, 0, 4'hF, 0, 2'b00);
      drain();
      push_r(32'hDEADBEEF, 2'b00, 1'b1);
      read_burst(28'h10, 0, -1);
      drain();

      tname = "strobe";
      wd[0] = 32'h11223344;
      write_burst(28'h20, 0, 4'hF, 0, 2'b00);
      drain();
      wd[0] = 32'hAABBCCDD;
      write_burst(28'h20, 0, 4'b0101, 0, 2'b00);
      drain();
      push_r(32'h11BB33DD, 2'b00, 1'b1);
      read_burst(28'h20, 0, -1);
      drain();

      tname = "burst_stall";
      for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
      write_burst(28'h100, 3, 4'hF, 3, 2'b00);
      drain();
      push_r(32'd1, 2'b00, 1'b0);
      push_r(32'd2, 2'b00, 1'b0);
      push_r(32'd3, 2'b00, 1'b0);
      push_r(32'd4, 2'b00, 1'b1);
      read_burst(28'h100, 3, 1);
      drain();

      tname = "top_of_ram";
      wd[0] = 32'h00000055;
      write_burst(28'h0, 0, 4'hF, 0, 2'b00);
      drain();
      wd[0] = 32'hCAFEF00D;
      wd[1] = 32'h12345678;
      write_burst(28'h1FFC, 1, 4'hF, 1, 2'b10);
      drain();
      push_r(32'hCAFEF00D, 2'b00, 1'b0);
      push_r(32'h0, 2'b10, 1'b1);
      read_burst(28'h1FFC, 1, -1);
      drain();
      push_r(32'h00000055, 2'b00, 1'b1);
      read_burst(28'h0, 0, -1);
      drain();

      tname = "early_wlast";
      wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2;
      write_burst(28'h200, 2, 4'hF, 0, 2'b10);
      drain();
      push_r(32'hA0, 2'b00, 1'b0);
      push_r(32'hA1, 2'b00, 1'b0);
      push_r(32'hA2, 2'b00, 1'b1);
      read_burst(28'h200, 2, -1);
      drain();

      tname = "read_first";
      wd[0] = 32'd7;
      write_burst(28'h14, 0, 4'hF, 0, 2'b00);
      drain();
      wd[0] = 32'd9;
      fork
         write_burst(28'h14, 0, 4'hF, 0, 2'b00);
         begin
            push_r(32'd7, 2'b00, 1'b1);
            read_burst(28'h14, 0, -1);
         end
      join
      drain();
      push_r(32'd9, 2'b00, 1'b1);
      read_burst(28'h14, 0, -1);
      drain();

      tname = "reset_mid_read";
      for (int i = 0; i < 8; i++) wd[i] = 32'h300 + 32'(i);
      write_burst(28'h300, 7, 4'hF, 7, 2'b00);
      drain();
      push_r(32'h300, 2'b00, 1'b0);
      push_r(32'h301, 2'b00, 1'b0);
      push_r(32'h302, 2'b00, 1'b0);
      ar_send(28'h300, 8'd7);
      for (int i = 0; i < 2; i++) begin
         wait_rvalid(n);
         @(posedge CLK);
         #1;
      end
      RREADY = 1'b0;
      wait_rvalid(n);
      @(posedge CLK);
      #1 RSTN = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("rvalid_in_reset", RVALID, 1'b0);
      rq.delete();
      @(posedge CLK);
      #1 RSTN = 1'b1;
      RREADY = 1'b1;
      @(negedge CLK);
      chk("idle_after_rst", {ARREADY, RVALID, BVALID}, 3'b100);
      @(posedge CLK);
      #1;
      push_r(32'h300, 2'b00, 1'b1);
      read_burst(28'h300, 0, -1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog [%s]", tname);
      $fatal(1, "watchdog expired");
   end

endmodule
